// File: rtl/seq_divider_4bits_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_4bits_pkg
//   Shared definitions for the sequential restoring divider:
//     - WIDTH_DEF : default operand/result width
//     - state_e   : controller state encoding (IDLE, RUN, DONE)
//     - cnt_width : width of the iteration counter for a given operand width
// ---------------------------------------------------------------------------
package seq_divider_4bits_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter runs 0..width-1, so it needs clog2(width) bits (at least 1).
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage : seq_divider_4bits_pkg

// File: rtl/seq_divider_4bits_sub.sv
// ---------------------------------------------------------------------------
// sub_nbits
//   N-bit ripple subtractor built as a + ~b + 1.
//   Ports:
//     a_i      : minuend
//     b_i      : subtrahend
//     diff_o   : a_i - b_i modulo 2^N
//     borrow_o : 1 when a_i < b_i (inverted carry out of the adder chain)
// ---------------------------------------------------------------------------
module sub_nbits #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;

  assign b_inv    = ~b_i;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff_o[i]  = a_i[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_inv[i]) | (carry[i] & (a_i[i] ^ b_inv[i]));
  end

  // No carry out of a + ~b + 1 means the subtraction wrapped: a < b.
  assign borrow_o = ~carry[N];

endmodule : sub_nbits

// File: rtl/seq_divider_4bits.sv
// ---------------------------------------------------------------------------
// seq_divider_4bits
//   Unsigned restoring shift-subtract divider, one quotient bit per clock.
//   A division accepted at edge E0 finishes at edge E(WIDTH); a zero divisor
//   finishes at E1 with quotient all-ones and remainder = dividend.
//   Ports:
//     clk         : clock, all state changes on the rising edge
//     rst         : synchronous active-high reset
//     start       : request a division (taken in IDLE or DONE only)
//     dividend    : numerator, latched on acceptance
//     divisor     : denominator, latched on acceptance
//     quotient    : result of the last completed division
//     remainder   : remainder of the last completed division
//     busy        : high while iterating (RUN)
//     done        : one-cycle pulse when quotient/remainder update
//     div_by_zero : last completed division had a zero divisor
// ---------------------------------------------------------------------------
module seq_divider_4bits
  import seq_divider_4bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int                 CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  // Controller state
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zpend_q;   // zero-divisor completion scheduled for next edge

  // Datapath state
  logic [WIDTH:0]   prem_q;    // partial remainder, one guard bit wide
  logic [WIDTH-1:0] dvd_q;     // dividend, shifted out MSB-first
  logic [WIDTH-1:0] dsr_q;     // latched divisor
  logic [WIDTH-1:0] qacc_q;    // quotient bits collected so far

  // Registered outputs
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  // Next-iteration datapath values
  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   diff_d;
  logic             borrow_d;
  logic             qbit_d;
  logic [WIDTH:0]   prem_d;
  logic [WIDTH-1:0] qacc_d;
  logic             accept_d;

  // Shift the partial remainder left and bring in the next dividend bit.
  assign shift_d = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  sub_nbits #(
    .N (WIDTH + 1)
  ) u_sub (
    .a_i      (shift_d),
    .b_i      ({1'b0, dsr_q}),
    .diff_o   (diff_d),
    .borrow_o (borrow_d)
  );

  // Borrow means the trial subtraction went negative: restore (keep shift_d).
  assign qbit_d = ~borrow_d;
  assign prem_d = borrow_d ? shift_d : diff_d;
  assign qacc_d = {qacc_q[WIDTH-2:0], qbit_d};

  // A request is taken in IDLE (unless a zero-divisor result is pending)
  // and in DONE, which gives back-to-back operation.
  assign accept_d = start &&
                    (((state_q == ST_IDLE) && !zpend_q) || (state_q == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      zpend_q <= 1'b0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qacc_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_d) begin
        dvd_q  <= dividend;
        dsr_q  <= divisor;
        cnt_q  <= '0;
        prem_q <= '0;
        qacc_q <= '0;
        if (divisor == '0) begin
          // Result is produced on the following edge without iterating.
          zpend_q <= 1'b1;
          state_q <= ST_IDLE;
        end else begin
          busy_q  <= 1'b1;
          state_q <= ST_RUN;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (zpend_q) begin
              quot_q  <= '1;
              rem_q   <= dvd_q;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              zpend_q <= 1'b0;
              state_q <= ST_DONE;
            end
          end
          ST_RUN: begin
            prem_q <= prem_d;
            dvd_q  <= dvd_q << 1;
            qacc_q <= qacc_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              quot_q  <= qacc_d;
              rem_q   <= prem_d[WIDTH-1:0];
              dbz_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider_4bits

// File: tb/tb_seq_divider_4bits.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_4bits
//   Directed self-checking bench for seq_divider_4bits (WIDTH = 4).
// ---------------------------------------------------------------------------
module tb_seq_divider_4bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_divider_4bits #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch a division and wait (bounded) for done; lat = edges after E0.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int eq, er;
    logic [3:0] qs, rs;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    check("rst_q",    32'(quotient),    32'd0);
    check("rst_r",    32'(remainder),   32'd0);
    check("rst_busy", 32'(busy),        32'd0);
    check("rst_done", 32'(done),        32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    // 13 / 3 with cycle-by-cycle busy/done
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    check("13_3_busyE0", 32'(busy), 32'd1);
    tick(); check("13_3_busyE1", 32'(busy), 32'd1); check("13_3_doneE1", 32'(done), 32'd0);
    tick(); check("13_3_busyE2", 32'(busy), 32'd1);
    tick(); check("13_3_busyE3", 32'(busy), 32'd1); check("13_3_doneE3", 32'(done), 32'd0);
    tick();                                   // E4
    check("13_3_doneE4", 32'(done),        32'd1);
    check("13_3_busyE4", 32'(busy),        32'd0);
    check("13_3_q",      32'(quotient),    32'd4);
    check("13_3_r",      32'(remainder),   32'd1);
    check("13_3_dbz",    32'(div_by_zero), 32'd0);
    tick();
    check("13_3_donepulse", 32'(done),     32'd0);
    check("13_3_qhold",     32'(quotient), 32'd4);
    tick();

    // 15 / 1 and 7 / 9
    do_div(4'd15, 4'd1, lat);
    check("15_1_lat", 32'(lat), 32'd4);
    check("15_1_q", 32'(quotient),  32'd15);
    check("15_1_r", 32'(remainder), 32'd0);
    tick();
    do_div(4'd7, 4'd9, lat);
    check("7_9_lat", 32'(lat), 32'd4);
    check("7_9_q", 32'(quotient),  32'd0);
    check("7_9_r", 32'(remainder), 32'd7);
    tick();

    // 5 / 0 then 6 / 2
    do_div(4'd5, 4'd0, lat);
    check("5_0_lat",  32'(lat),         32'd1);
    check("5_0_q",    32'(quotient),    32'hF);
    check("5_0_r",    32'(remainder),   32'h5);
    check("5_0_dbz",  32'(div_by_zero), 32'd1);
    tick();
    check("5_0_dbzhold", 32'(div_by_zero), 32'd1);
    do_div(4'd6, 4'd2, lat);
    check("6_2_q",   32'(quotient),    32'd3);
    check("6_2_dbz", 32'(div_by_zero), 32'd0);
    tick();

    // 12 / 5 with a 9 / 3 request during RUN
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    dividend = 4'd9; divisor = 4'd3; start = 1'b1;
    tick();                                   // E2
    start = 1'b0;
    ndone = 0; qs = '0; rs = '0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        ndone++;
        qs = quotient;
        rs = remainder;
      end
      tick();
    end
    check("12_5_ndone", 32'(ndone), 32'd1);
    check("12_5_q",     32'(qs),    32'd2);
    check("12_5_r",     32'(rs),    32'd2);

    // Reset at E2 of 14 / 4, with start also high during reset
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    rst = 1'b1; start = 1'b1;
    tick();                                   // E2
    rst = 1'b0; start = 1'b0;
    check("rst2_q",    32'(quotient),    32'd0);
    check("rst2_r",    32'(remainder),   32'd0);
    check("rst2_busy", 32'(busy),        32'd0);
    check("rst2_done", 32'(done),        32'd0);
    check("rst2_dbz",  32'(div_by_zero), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("rst2_nodone", 32'(ndone), 32'd0);
    do_div(4'd14, 4'd4, lat);
    check("14_4_q", 32'(quotient),  32'd3);
    check("14_4_r", 32'(remainder), 32'd2);
    tick();

    // Start held across DONE: 8 / 3 then 11 / 2 accepted in the done cycle
    dividend = 4'd8; divisor = 4'd3; start = 1'b1;
    tick();                                   // E0
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat1", 32'(lat),       32'd4);
    check("b2b_q1",   32'(quotient),  32'd2);
    check("b2b_r1",   32'(remainder), 32'd2);
    dividend = 4'd11; divisor = 4'd2;
    tick();                                   // accepted in DONE
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat2", 32'(lat),       32'd4);
    check("b2b_q2",   32'(quotient),  32'd5);
    check("b2b_r2",   32'(remainder), 32'd1);
    tick();

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b), lat);
        if (b == 0) begin
          eq = 15;
          er = a;
        end else begin
          eq = a / b;
          er = a % b;
        end
        check($sformatf("sweep_%0d_%0d", a, b),
              {23'd0, div_by_zero, quotient, remainder},
              {23'd0, (b == 0), 4'(eq), 4'(er)});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seq_divider_4bits

// File: doc/seq_divider_4bits.md
SEQ_DIVIDER_4BITS -- requirements
Module: seq_divider_4bits

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 The module SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, request a division; sampled only when idle.
REQ-005 The module SHALL have port dividend, input, WIDTH, numerator; latched when start is accepted.
REQ-006 The module SHALL have port divisor, input, WIDTH, denominator; latched when start is accepted.
REQ-007 The module SHALL have port quotient, output, WIDTH, result of the last completed division.
REQ-008 The module SHALL have port remainder, output, WIDTH, remainder of the last completed division.
REQ-009 The module SHALL have port busy, output, 1, high while a division is in progress.
REQ-010 The module SHALL have port done, output, 1, one-cycle pulse when quotient and remainder become valid.
REQ-011 The module SHALL have port div_by_zero, output, 1, high when the last completed division had divisor zero.

Function
REQ-012 The module SHALL implement an unsigned restoring shift-subtract divider with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at edge E0 SHALL latch both operands, clear the iteration counter and, for a non-zero divisor, enter RUN.
REQ-014 Each RUN cycle SHALL shift the (WIDTH+1)-bit partial remainder left by one, bringing in the next dividend MSB.
REQ-015 Each RUN cycle SHALL subtract the divisor as a + ~b + 1 at WIDTH+1 bits, keep the difference when non-negative, and shift in quotient bit 1, else 0.
REQ-016 RUN SHALL last exactly WIDTH edges (E1..E4 for WIDTH=4); at E4 quotient, remainder and done=1 SHALL update and the state SHALL move to DONE.
REQ-017 done SHALL be high for exactly one cycle, then the state SHALL return to IDLE.
REQ-018 busy SHALL be high from the cycle after E0 through the last RUN cycle, and low in IDLE and DONE.
REQ-019 start SHALL be ignored while busy=1; the operation in progress SHALL be unaffected.
REQ-020 start=1 in DONE SHALL be accepted exactly as in IDLE, allowing back-to-back operations.
REQ-021 If divisor=0 at acceptance, the next edge SHALL set quotient to all-ones, remainder to dividend, div_by_zero=1 and done=1, skipping RUN.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values until the next completion.
REQ-023 div_by_zero SHALL clear at the completion of any division with a non-zero divisor.
REQ-024 The result for a non-zero divisor SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and clear the counter and partial remainder.
REQ-026 rst=1 at a clock edge SHALL set quotient, remainder, busy, done and div_by_zero to 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; start SHALL be ignored while rst=1.

Structure
REQ-028 A shared package SHALL hold the WIDTH default, the state encoding (IDLE, RUN, DONE) and the iteration-counter width.
REQ-029 The (WIDTH+1)-bit ripple subtractor SHALL be a separate sub-module, sub_nbits (inverted b, carry-in 1, borrow out).
REQ-030 The sub_nbits borrow out SHALL select restore vs. keep.

Verification
REQ-031 Bench: dividend=13, divisor=3, start at E0 -> busy during E1..E4, done at E4, quotient=4, remainder=1, div_by_zero=0.
REQ-032 Bench: 15/1 -> quotient=15, remainder=0; 7/9 -> quotient=0, remainder=7.
REQ-033 Bench: 5/0 -> done at E1, quotient=4'b1111, remainder=4'b0101, div_by_zero=1; then 6/2 -> quotient=3, div_by_zero=0.
REQ-034 Bench: 12/5 started, start pulsed with 9/3 during RUN -> single done, quotient=2, remainder=2.
REQ-035 Bench: rst at E2 of 14/4 -> all outputs 0 next cycle, no done; fresh 14/4 -> quotient=3, remainder=2.
REQ-036 Bench: start held high across DONE -> second operation accepted in the done cycle; exhaustive 256-pair sweep matches / and %.
